combo_match_det: RTL and testbench



---
 rtl/combo_match_det.sv | 130 +++++++++++++
 tb/tb_combo_match_det.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/combo_match_det.sv
// combo_match_det: registered, parametrised pattern/mask match detector.
// A match must hold for HOLD consecutive enabled samples before one hit
// pulse is raised. Reset defaults reproduce the legacy Y = ~A&B&C&~D gate.
// Optional saturating hit counter: define COMBO_MATCH_DET_CNT_EN.
module combo_match_det #(
    parameter int               WIDTH    = 4,
    parameter int               HOLD     = 3,
    parameter logic [WIDTH-1:0] PAT_RST  = 4'b0110,
    parameter logic [WIDTH-1:0] MASK_RST = 4'b1111,
    parameter int               CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic [WIDTH-1:0] pat_in,
    input  logic [WIDTH-1:0] mask_in,
    output logic             y,
    output logic             hit,
    output logic             locked,
    output logic [CNT_W-1:0] hit_count
);

    localparam int               RUN_W  = $clog2(HOLD + 1);
    localparam logic [RUN_W-1:0] HOLD_V = RUN_W'(HOLD);

    typedef enum logic [1:0] {IDLE, TRACK, LOCK} state_t;

    state_t           state, state_nxt;
    logic [RUN_W-1:0] run, run_nxt;
    logic [WIDTH-1:0] pattern, mask;
    logic             raw;
    logic             hit_nxt;

    // Raw match: a bit can only veto the match where the care mask is set.
    assign raw    = &(~((din ^ pattern) & mask));
    assign locked = (state == LOCK);

    // State, run length, pattern/mask and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            run     <= '0;
            pattern <= PAT_RST;
            mask    <= MASK_RST;
            y       <= 1'b0;
            hit     <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
            hit   <= hit_nxt;
            // The sample on a load edge is still judged with the old pattern.
            if (en) begin
                y <= raw;
            end
            if (load) begin
                pattern <= pat_in;
                mask    <= mask_in;
            end
        end
    end

    // Next-state logic; en=0 cycles leave the run and state untouched.
    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        hit_nxt   = 1'b0;
        if (load) begin
            state_nxt = IDLE;
            run_nxt   = '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (raw) begin
                        if (HOLD == 1) begin
                            state_nxt = LOCK;
                            run_nxt   = HOLD_V;
                            hit_nxt   = 1'b1;
                        end else begin
                            state_nxt = TRACK;
                            run_nxt   = RUN_W'(1);
                        end
                    end
                end
                TRACK: begin
                    if (!raw) begin
                        state_nxt = IDLE;
                        run_nxt   = '0;
                    end else if (run + RUN_W'(1) == HOLD_V) begin
                        state_nxt = LOCK;
                        run_nxt   = HOLD_V;
                        hit_nxt   = 1'b1;
                    end else begin
                        run_nxt = run + RUN_W'(1);
                    end
                end
                LOCK: begin
                    // A continuous match stays here without re-firing.
                    if (!raw) begin
                        state_nxt = IDLE;
                        run_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    run_nxt   = '0;
                end
            endcase
        end
    end

`ifdef COMBO_MATCH_DET_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Saturating hit counter, cleared only by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (hit_nxt && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign hit_count = cnt;
`else
    assign hit_count = '0;
`endif

endmodule

// File: tb/tb_combo_match_det.sv
// Directed bench for combo_match_det (default parameters plus a CNT_W=2
// instance for counter saturation). Expected values are hand-computed.
module tb_combo_match_det;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] din;
    logic       load;
    logic [3:0] pat_in;
    logic [3:0] mask_in;
    logic       y, hit, locked;
    logic [7:0] hit_count;
    logic       y2, hit2, locked2;
    logic [1:0] hit_count2;

    int checks = 0;
    int errors = 0;
    int hits   = 0;

    combo_match_det dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .load(load),
        .pat_in(pat_in), .mask_in(mask_in),
        .y(y), .hit(hit), .locked(locked), .hit_count(hit_count)
    );

    combo_match_det #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .load(load),
        .pat_in(pat_in), .mask_in(mask_in),
        .y(y2), .hit(hit2), .locked(locked2), .hit_count(hit_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_cnt(input int n);
`ifdef COMBO_MATCH_DET_CNT_EN
        return (n > 255) ? 255 : n;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_cnt2(input int n);
`ifdef COMBO_MATCH_DET_CNT_EN
        return (n > 3) ? 3 : n;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus and land 1 time unit after the edge.
    task automatic cyc(input logic e, input logic [3:0] d);
        en  = e;
        din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; din = 4'h0; load = 1'b0;
        pat_in = 4'h0; mask_in = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_y", y, 0);
        chk("rst_hit", hit, 0);
        chk("rst_locked", locked, 0);
        chk("rst_cnt", hit_count, 0);
        rst_n = 1'b1;

        // 1: sweep; only din=0110 matches, no hit.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 4'(i));
            chk($sformatf("sweep_y_%0d", i), y, (i == 6) ? 1 : 0);
            chk($sformatf("sweep_hit_%0d", i), hit, 0);
        end
        // en=0 holds y even with a matching din.
        cyc(1'b0, 4'b0110);
        chk("en0_y_hold", y, 0);

        // 2: continuous match, exactly one hit on the 3rd sample.
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 4'b0110);
            if (i == 3) hits++;
            chk($sformatf("cont_hit_%0d", i), hit, (i == 3) ? 1 : 0);
            chk($sformatf("cont_locked_%0d", i), locked, (i >= 3) ? 1 : 0);
        end
        chk("cont_cnt", hit_count, exp_cnt(hits));
        cyc(1'b1, 4'b0000);
        chk("unlock", locked, 0);
        chk("unlock_y", y, 0);

        // 3: broken runs never qualify.
        for (int r = 0; r < 3; r++) begin
            cyc(1'b1, 4'b0110);
            cyc(1'b1, 4'b0110);
            chk($sformatf("brk_hit_%0d", r), hit, 0);
            cyc(1'b1, 4'b0000);
            chk($sformatf("brk_locked_%0d", r), locked, 0);
        end

        // 4: en=0 gap is transparent to the run.
        cyc(1'b1, 4'b0110);
        cyc(1'b1, 4'b0110);
        for (int g = 0; g < 4; g++) begin
            cyc(1'b0, 4'b0000);
            chk($sformatf("gap_hit_%0d", g), hit, 0);
            chk($sformatf("gap_y_%0d", g), y, 1);
        end
        cyc(1'b1, 4'b0110);
        hits++;
        chk("gap_hit_final", hit, 1);
        chk("gap_locked", locked, 1);
        cyc(1'b1, 4'b0000);

        // 5: load mid-TRACK clears run and suppresses hit.
        cyc(1'b1, 4'b0110);
        cyc(1'b1, 4'b0110);
        load = 1'b1; pat_in = 4'b1000; mask_in = 4'b1011;
        cyc(1'b1, 4'b0110);
        load = 1'b0;
        chk("load_hit", hit, 0);
        chk("load_old_pat_y", y, 1);
        chk("load_locked", locked, 0);
        chk("load_keeps_cnt", hit_count, exp_cnt(hits));
        cyc(1'b1, 4'b1100);
        chk("newpat_y", y, 1);
        chk("newpat_hit1", hit, 0);
        cyc(1'b1, 4'b1000);
        chk("newpat_hit2", hit, 0);
        cyc(1'b1, 4'b1100);
        hits++;
        chk("newpat_hit3", hit, 1);
        chk("newpat_cnt", hit_count, exp_cnt(hits));
        cyc(1'b1, 4'b0110);
        chk("oldpat_nomatch_y", y, 0);
        chk("oldpat_unlock", locked, 0);

        // 6: async reset mid-TRACK.
        cyc(1'b1, 4'b1000);
        cyc(1'b1, 4'b1000);
        chk("pre_rst_y", y, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_y", y, 0);
        chk("async_rst_hit", hit, 0);
        chk("async_rst_locked", locked, 0);
        chk("async_rst_cnt", hit_count, 0);
        chk("async_rst_cnt2", hit_count2, 0);
        hits = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pattern reverted to 0110; five hits saturate the CNT_W=2 counter.
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 4'b0110);
            chk($sformatf("sat_y_%0d", k), y, 1);
            cyc(1'b1, 4'b0110);
            cyc(1'b1, 4'b0110);
            hits++;
            chk($sformatf("sat_hit_%0d", k), hit, 1);
            chk($sformatf("sat_cnt_%0d", k), hit_count, exp_cnt(hits));
            chk($sformatf("sat_cnt2_%0d", k), hit_count2, exp_cnt2(hits));
            cyc(1'b1, 4'b0000);
        end

        // All-zero mask matches anything.
        load = 1'b1; pat_in = 4'b0000; mask_in = 4'b0000;
        cyc(1'b1, 4'b0000);
        load = 1'b0;
        cyc(1'b1, 4'b0101);
        chk("mask0_y", y, 1);
        chk("mask0_hit", hit, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
